// File: rtl/ula_controle_multiciclo.sv
// Multicycle MIPS control unit: walks each instruction through fetch, decode,
// execute, memory and writeback, and drives the ALU op code plus every
// datapath enable from the current state (Moore-style).
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode, funct     IR[31:26] / IR[5:0], stable from DECODE until FETCH
//   zero              ALU zero flag, used in BRANCH
//   pc_en .. pc_source  datapath enables and mux selects
//   ula_control       4-bit ALU op (add/sub/and/or/slt)
//   illegal           one-cycle pulse on an unsupported opcode or funct
//   state             current state encoding (debug)
//   instr_count       retired-instruction counter, wraps silently
module ula_controle_multiciclo #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             ula_src_a,
    output logic [1:0]       ula_src_b,
    output logic [3:0]       ula_control,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_R_WB      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_ADDI = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;
    logic              w_wait_done;
    logic              w_retire;

    assign w_wait_done = (r_wait == WAIT_MAX);
    assign state       = r_state;
    assign instr_count = r_count;

    // State, wait counter and retire counter. The wait counter only advances
    // while a memory state holds itself; any state change clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next == r_state) ? r_wait + WAIT_W'(1) : '0;
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_next      = S_FETCH;
        w_retire    = 1'b0;
        pc_en       = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        ula_src_a   = 1'b0;
        ula_src_b   = 2'b00;
        ula_control = ALU_ADD;
        pc_source   = 2'b00;
        illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ula_src_b = 2'b01;
                // IR and PC load only once memory data is valid.
                if (w_wait_done) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    w_next   = S_DECODE;
                end else begin
                    w_next   = S_FETCH;
                end
            end
            S_DECODE: begin
                ula_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      w_next = S_EXEC_R;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_EXEC_ADDI;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ula_src_a = 1'b1;
                w_next    = S_R_WB;
                case (funct)
                    FN_ADD: ula_control = ALU_ADD;
                    FN_SUB: ula_control = ALU_SUB;
                    FN_AND: ula_control = ALU_AND;
                    FN_OR:  ula_control = ALU_OR;
                    FN_SLT: ula_control = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                w_retire  = 1'b1;
            end
            S_MEM_ADDR: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                w_next   = w_wait_done ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                w_next    = w_wait_done ? S_FETCH : S_MEM_WRITE;
                w_retire  = w_wait_done;
            end
            S_BRANCH: begin
                ula_src_a   = 1'b1;
                ula_control = ALU_SUB;
                pc_source   = 2'b01;
                pc_en       = (opcode == OP_BNE) ? ~zero : zero;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                w_retire  = 1'b1;
            end
            S_EXEC_ADDI: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_ula_controle_multiciclo.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle
// trace (state, output bundle, retire count); a negedge monitor pops and
// compares. Three instances (MEM_WAIT 0/2/3); unselected ones sit in reset.
module tb_ula_controle_multiciclo;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_R_WB  = 4'd3,  ST_MEM_ADDR = 4'd4, ST_MEM_READ = 4'd5;
    localparam logic [3:0] ST_MEM_WB = 4'd6, ST_MEM_WRITE = 4'd7, ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP = 4'd9,   ST_EXEC_ADDI = 4'd10, ST_I_WB = 4'd11;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] o;
        logic [31:0] cnt;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_tb;
    int         sel;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    wire [3:0]  st_v   [3];
    wire [17:0] outs_v [3];
    wire [31:0] cnt_v  [3];

    rec_t  sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_count;
    int    cut_left;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        pc_en, i_or_d, mem_read, mem_write, ir_write;
        logic        reg_dst, mem_to_reg, reg_write, ula_src_a, illegal;
        logic [1:0]  ula_src_b, pc_source;
        logic [3:0]  ula_control, state;
        logic [31:0] instr_count;

        ula_controle_multiciclo #(
            .MEM_WAIT(g == 0 ? 0 : g + 1),
            .CNT_W   (32)
        ) u_dut (
            .clk        (clk),
            .reset      (reset_tb || (sel != g)),
            .opcode     (opcode),
            .funct      (funct),
            .zero       (zero),
            .pc_en      (pc_en),
            .i_or_d     (i_or_d),
            .mem_read   (mem_read),
            .mem_write  (mem_write),
            .ir_write   (ir_write),
            .reg_dst    (reg_dst),
            .mem_to_reg (mem_to_reg),
            .reg_write  (reg_write),
            .ula_src_a  (ula_src_a),
            .ula_src_b  (ula_src_b),
            .ula_control(ula_control),
            .pc_source  (pc_source),
            .illegal    (illegal),
            .state      (state),
            .instr_count(instr_count)
        );

        assign outs_v[g] = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                            mem_to_reg, reg_write, ula_src_a, ula_src_b,
                            ula_control, pc_source, illegal};
        assign st_v[g]   = state;
        assign cnt_v[g]  = instr_count;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Expected output bundle, same field order as outs_v.
    function automatic logic [17:0] mk(input logic pce, input logic iod, input logic mr,
                                       input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic sa,
                                       input logic [1:0] sb, input logic [3:0] ctl,
                                       input logic [1:0] pcs, input logic ill);
        return {pce, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ctl, pcs, ill};
    endfunction

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : s + 1;
    endfunction

    task automatic push(input logic [3:0] st, input logic [17:0] o, input logic ret);
        rec_t r;
        if (cut_left == 0) return;
        cut_left--;
        r.st  = st;
        r.o   = o;
        r.cnt = 32'(exp_count);
        sb_q.push_back(r);
        if (ret) exp_count++;
    endtask

    // Wait until the monitor has consumed every expected record.
    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb_q.size() != 0 && n < 300);
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check("state", 32'(st_v[sel]), 32'(r.st));
            check("outs",  32'(outs_v[sel]), 32'(r.o));
            check("count", cnt_v[sel], r.cnt);
        end
    end

    // Called in the first FETCH cycle; pushes the full trace, or only the
    // first `cut` records when cut > 0.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cut);
        int         w;
        logic       legal;
        logic       ok;
        logic [3:0] c;
        w        = wait_of(sel);
        cut_left = (cut > 0) ? cut : 1000;
        opcode   = op;
        funct    = fn;
        zero     = z;
        for (int i = 0; i <= w; i++)
            push(ST_FETCH, mk(i == w, N, Y, N, i == w, N, N, N, N, 2'b01, 4'h0, 2'b00, N), N);
        legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) ||
                (op == 6'h05) || (op == 6'h02) || (op == 6'h08);
        push(ST_DECODE, mk(N, N, N, N, N, N, N, N, N, 2'b11, 4'h0, 2'b00, !legal), N);
        case (op)
            6'h00: begin
                ok = Y;
                case (fn)
                    6'h20: c = 4'h0;
                    6'h22: c = 4'h1;
                    6'h24: c = 4'h2;
                    6'h25: c = 4'h3;
                    6'h2a: c = 4'h4;
                    default: begin c = 4'h0; ok = N; end
                endcase
                push(ST_EXEC_R, mk(N, N, N, N, N, N, N, N, Y, 2'b00, c, 2'b00, !ok), N);
                if (ok) push(ST_R_WB, mk(N, N, N, N, N, Y, N, Y, N, 2'b00, 4'h0, 2'b00, N), Y);
            end
            6'h23, 6'h2b: begin
                push(ST_MEM_ADDR, mk(N, N, N, N, N, N, N, N, Y, 2'b10, 4'h0, 2'b00, N), N);
                if (op == 6'h23) begin
                    for (int i = 0; i <= w; i++)
                        push(ST_MEM_READ, mk(N, Y, Y, N, N, N, N, N, N, 2'b00, 4'h0, 2'b00, N), N);
                    push(ST_MEM_WB, mk(N, N, N, N, N, N, Y, Y, N, 2'b00, 4'h0, 2'b00, N), Y);
                end else begin
                    for (int i = 0; i <= w; i++)
                        push(ST_MEM_WRITE, mk(N, Y, N, Y, N, N, N, N, N, 2'b00, 4'h0, 2'b00, N), i == w);
                end
            end
            6'h04, 6'h05:
                push(ST_BRANCH, mk((op == 6'h04) ? z : !z, N, N, N, N, N, N, N, Y, 2'b00,
                                   4'h1, 2'b01, N), Y);
            6'h02:
                push(ST_JUMP, mk(Y, N, N, N, N, N, N, N, N, 2'b00, 4'h0, 2'b10, N), Y);
            6'h08: begin
                push(ST_EXEC_ADDI, mk(N, N, N, N, N, N, N, N, Y, 2'b10, 4'h0, 2'b00, N), N);
                push(ST_I_WB, mk(N, N, N, N, N, N, N, Y, N, 2'b00, 4'h0, 2'b00, N), Y);
            end
            default: ;
        endcase
        drain();
    endtask

    // Select instance n, hold reset one cycle and check the reset state.
    task automatic do_reset(input int n);
        logic f;
        reset_tb  = 1'b1;
        sel       = n;
        exp_count = 0;
        cut_left  = 1000;
        f         = (wait_of(n) == 0);
        @(posedge clk);
        #1;
        push(ST_FETCH, mk(f, N, Y, N, f, N, N, N, N, 2'b01, 4'h0, 2'b00, N), N);
        drain();
        reset_tb = 1'b0;
    endtask

    initial begin
        reset_tb = 1'b1;
        sel      = 0;
        opcode   = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;

        // MEM_WAIT = 0
        do_reset(0);
        issue(6'h00, 6'h20, N, 0);                  // add
        issue(6'h23, 6'h00, N, 0);                  // lw
        issue(6'h04, 6'h00, Y, 0);                  // beq taken
        issue(6'h04, 6'h00, N, 0);                  // beq not taken
        issue(6'h05, 6'h00, Y, 0);                  // bne not taken
        begin
            logic [5:0] fns [4];
            fns = '{6'h22, 6'h24, 6'h25, 6'h2a};
            foreach (fns[k]) issue(6'h00, fns[k], N, 0);
        end
        issue(6'h00, 6'h07, N, 0);                  // unknown funct
        issue(6'h3f, 6'h00, N, 0);                  // unknown opcode
        issue(6'h2b, 6'h00, N, 0);                  // sw
        issue(6'h02, 6'h00, N, 0);                  // j
        issue(6'h08, 6'h00, N, 0);                  // addi

        // Reset landing on a writeback cycle: reg_write still 1, count cleared.
        issue(6'h08, 6'h00, N, 3);
        reset_tb = 1'b1;
        cut_left = 1000;
        push(ST_I_WB, mk(N, N, N, N, N, N, N, Y, N, 2'b00, 4'h0, 2'b00, N), N);
        drain();
        reset_tb  = 1'b0;
        exp_count = 0;
        issue(6'h02, 6'h00, N, 0);

        // MEM_WAIT = 2
        do_reset(1);
        issue(6'h23, 6'h00, N, 0);                  // lw, 9 cycles
        issue(6'h2b, 6'h00, N, 0);
        issue(6'h00, 6'h2a, N, 0);

        // MEM_WAIT = 3: reset in the middle of the MEM_WRITE wait.
        do_reset(2);
        issue(6'h02, 6'h00, N, 0);
        issue(6'h2b, 6'h00, N, 8);                  // stops after two MEM_WRITE cycles
        reset_tb = 1'b1;
        cut_left = 1000;
        push(ST_MEM_WRITE, mk(N, Y, N, Y, N, N, N, N, N, 2'b00, 4'h0, 2'b00, N), N);
        drain();
        reset_tb  = 1'b0;
        exp_count = 0;
        issue(6'h08, 6'h00, N, 0);
        issue(6'h23, 6'h00, N, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ula_controle_multiciclo.md
Name: ula_controle_multiciclo

Overview:
- Multicycle MIPS control unit: the issuing side of the ALU interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 4-bit ula_control code and all datapath enables; consumes the ALU zero flag for branches.
- Sits between the instruction register (opcode/funct) and the datapath muxes, register file, memory and PC.

Parameters:
- MEM_WAIT, 0: extra stall cycles inserted in every memory-access state (FETCH, MEM_READ, MEM_WRITE); range 0..15.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- opcode  input  6  IR[31:26]; stable from DECODE until return to FETCH.
- funct  input  6  IR[5:0]; same stability rule.
- zero  input  1  ALU zero flag, sampled in BRANCH.
- pc_en  output  1  PC load enable.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-data select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register-file write enable.
- ula_src_a  output  1  ALU A select: 0 = PC, 1 = regA.
- ula_src_b  output  2  ALU B select: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ula_control  output  4  ALU op code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt.
- pc_source  output  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump target.
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
- state  output  4  current state encoding, for debug.
- instr_count  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (synchronous): state = FETCH, wait counter = 0, instr_count = 0, illegal = 0.
- Moore-style outputs: all outputs not named in a state are 0; ula_control defaults to 0000.
- FETCH:
  - mem_read=1, ir_write=1, ula_src_a=0, ula_src_b=01, ula_control=0000, pc_source=00, pc_en=1.
  - With MEM_WAIT>0: ir_write and pc_en assert only in the final wait cycle; mem_read is held throughout.
  - Next state: DECODE.
- DECODE:
  - ula_src_a=0, ula_src_b=11, ula_control=0000 (branch target into ALUOut).
  - Next state by opcode: 000000 → EXEC_R; 100011 or 101011 → MEM_ADDR; 000100 or 000101 → BRANCH; 000010 → JUMP; 001000 → EXEC_ADDI.
  - Any other opcode: illegal=1 for one cycle, → FETCH, no count.
- EXEC_R:
  - ula_src_a=1, ula_src_b=00.
  - ula_control from funct: 100000 → 0000, 100010 → 0001, 100100 → 0010, 100101 → 0011, 101010 → 0100.
  - Next state: R_WB.
  - Unknown funct: illegal=1 this cycle, → FETCH, no R_WB, no count.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH; instr_count++.
- MEM_ADDR: ula_src_a=1, ula_src_b=10, ula_control=0000. Next state: MEM_READ if opcode=100011, else MEM_WRITE.
- MEM_READ: i_or_d=1, mem_read=1, held for 1+MEM_WAIT cycles → MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH; instr_count++.
- MEM_WRITE: i_or_d=1, mem_write=1 held for 1+MEM_WAIT cycles → FETCH; instr_count++ on exit.
- BRANCH:
  - ula_src_a=1, ula_src_b=00, ula_control=0001, pc_source=01.
  - pc_en = zero for beq (000100), pc_en = ~zero for bne (000101).
  - → FETCH; instr_count++ whether taken or not.
- JUMP: pc_source=10, pc_en=1 → FETCH; instr_count++.
- EXEC_ADDI: ula_src_a=1, ula_src_b=10, ula_control=0000 → I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH; instr_count++.
- Latency in cycles with MEM_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each memory state adds MEM_WAIT.
- Wait counter: 4-bit, cleared on entry to each memory state, compare against MEM_WAIT.
- Illegal states: unused state encodings → FETCH on the next edge.
- Counter overflow: instr_count wraps modulo 2^CNT_W with no flag.
- Reset mid-instruction: the next edge forces FETCH. Strobes drop in the cycle after reset is sampled, with no partial writeback. If reset coincides with a writeback state, reg_write is still 1 in that cycle; reset takes effect at that edge.

Test Plan:
- Reset, then add (op 000000, funct 100000) → state sequence FETCH, DECODE, EXEC_R, R_WB, FETCH; ula_control=0000 in EXEC_R; reg_write=1, reg_dst=1 in R_WB; instr_count=1.
- lw (100011), MEM_WAIT=0 then MEM_WAIT=2 → 5 then 9 cycles; mem_read high 1 then 3 cycles in MEM_READ; mem_to_reg=1 in MEM_WB.
- beq with zero=1, then zero=0; bne with zero=1 → pc_en=1, 0, 0 in BRANCH; pc_source=01; ula_control=0001; instr_count +3.
- Loop over funct 100010, 100100, 100101, 101010 → ula_control 0001, 0010, 0011, 0100 in EXEC_R. Funct 000111 → illegal pulse, no reg_write, count unchanged.
- Opcode 111111 → illegal=1 in DECODE, back to FETCH next cycle, no strobes.
- Assert reset during the MEM_WRITE wait (MEM_WAIT=3) → next cycle state=FETCH, mem_write=0, instr_count=0.
